// File: rtl/lfsr_gen.sv
// Parametrised Fibonacci/Galois LFSR with seed load, lockup recovery,
// period-wrap flag and a valid/ready output stream.
module lfsr_gen #(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] TAPS         = 32'h80200003,
    parameter int               MODE         = 0,
    parameter logic [WIDTH-1:0] DEFAULT_SEED = 32'h00000001
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             lockup,
    output logic             wrap,
    output logic [31:0]      step_cnt
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] LOAD = 2'd2;

    logic [1:0]       fsm_q, fsm_d;
    logic [WIDTH-1:0] state_q, state_d;
    logic [WIDTH-1:0] start_q, start_d;
    logic             lockup_q, lockup_d;
    logic             wrap_q, wrap_d;
    logic [31:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0] next_s;
    logic             fib_fb;
    logic             fire;

    always_comb begin
        fib_fb = ^(state_q & TAPS);
        if (MODE == 0) begin
            next_s = {state_q[WIDTH-2:0], fib_fb};
        end else begin
            next_s = {state_q[WIDTH-2:0], 1'b0} ^ ({WIDTH{state_q[WIDTH-1]}} & TAPS);
        end
    end

    assign fire = (fsm_q == RUN) & out_ready & ~seed_load;

    always_comb begin
        fsm_d    = fsm_q;
        state_d  = state_q;
        start_d  = start_q;
        lockup_d = lockup_q;
        wrap_d   = 1'b0;
        cnt_d    = cnt_q;
        if (seed_load) begin
            // A zero seed would lock the register; substitute the default.
            fsm_d    = LOAD;
            cnt_d    = 32'd0;
            state_d  = (seed == '0) ? DEFAULT_SEED : seed;
            start_d  = (seed == '0) ? DEFAULT_SEED : seed;
            lockup_d = (seed == '0);
        end else begin
            if (fire) begin
                state_d = next_s;
                cnt_d   = cnt_q + 32'd1;
                wrap_d  = (next_s == start_q);
            end
            case (fsm_q)
                IDLE:    fsm_d = en ? RUN : IDLE;
                RUN:     fsm_d = en ? RUN : IDLE;
                LOAD:    fsm_d = en ? RUN : IDLE;
                default: fsm_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q    <= IDLE;
            state_q  <= DEFAULT_SEED;
            start_q  <= DEFAULT_SEED;
            lockup_q <= 1'b0;
            wrap_q   <= 1'b0;
            cnt_q    <= 32'd0;
        end else begin
            fsm_q    <= fsm_d;
            state_q  <= state_d;
            start_q  <= start_d;
            lockup_q <= lockup_d;
            wrap_q   <= wrap_d;
            cnt_q    <= cnt_d;
        end
    end

    assign out_valid = (fsm_q == RUN);
    assign out_data  = state_q;
    assign lockup    = lockup_q;
    assign wrap      = wrap_q;
    assign step_cnt  = cnt_q;

endmodule
